// File: rtl/axil_bram_port_rr.sv
// Full-duplex AXI4-Lite slave onto one BRAM port: independent one-entry AW/W/AR buffers,
// round-robin arbitration between complete writes and reads, byte-lane writes.
module axil_bram_port_rr #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 1,
    localparam int BL = $clog2(DATA_WIDTH / 8),
    localparam int AXI_AW = ADDR_WIDTH + BL,
    localparam int SW = DATA_WIDTH / 8
) (
    input  logic                  axi_clock,
    input  logic                  rst_n,
    input  logic [AXI_AW-1:0]     s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [SW-1:0]         s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [AXI_AW-1:0]     s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_en,
    output logic [SW-1:0]         bram_we,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RWAIT, RRESP} state_t;

    state_t                state_reg;
    logic                  last_wr_reg;
    logic [1:0]            wait_cnt_reg;

    logic                  aw_full_reg, w_full_reg, ar_full_reg;
    logic                  aw_full_next, w_full_next, ar_full_next;
    logic                  awready_reg, wready_reg, arready_reg;
    logic [ADDR_WIDTH-1:0] aw_addr_reg, ar_addr_reg;
    logic [DATA_WIDTH-1:0] w_data_reg;
    logic [SW-1:0]         w_strb_reg;

    logic                  bvalid_reg, rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  bram_en_reg;
    logic [SW-1:0]         bram_we_reg;
    logic [ADDR_WIDTH-1:0] bram_addr_reg;
    logic [DATA_WIDTH-1:0] bram_din_reg;

    logic aw_take, w_take, ar_take, wr_req, rd_req;
    logic unused_bits;

    assign aw_take = s_axil_awvalid & awready_reg;
    assign w_take  = s_axil_wvalid & wready_reg;
    assign ar_take = s_axil_arvalid & arready_reg;
    assign wr_req  = aw_full_reg & w_full_reg;
    assign rd_req  = ar_full_reg;

    // Buffers empty out in the single cycle the FSM spends issuing their access.
    always_comb begin
        aw_full_next = aw_take | (aw_full_reg & (state_reg != WR));
        w_full_next  = w_take | (w_full_reg & (state_reg != WR));
        ar_full_next = ar_take | (ar_full_reg & (state_reg != RD));
    end

    always_ff @(posedge axi_clock or negedge rst_n) begin
        if (!rst_n) begin
            aw_full_reg <= 1'b0;
            w_full_reg  <= 1'b0;
            ar_full_reg <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            arready_reg <= 1'b0;
            aw_addr_reg <= '0;
            ar_addr_reg <= '0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
        end else begin
            aw_full_reg <= aw_full_next;
            w_full_reg  <= w_full_next;
            ar_full_reg <= ar_full_next;
            awready_reg <= ~aw_full_next;
            wready_reg  <= ~w_full_next;
            arready_reg <= ~ar_full_next;
            if (aw_take) aw_addr_reg <= s_axil_awaddr[AXI_AW-1:BL];
            if (ar_take) ar_addr_reg <= s_axil_araddr[AXI_AW-1:BL];
            if (w_take) begin
                w_data_reg <= s_axil_wdata;
                w_strb_reg <= s_axil_wstrb;
            end
        end
    end

    always_ff @(posedge axi_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            last_wr_reg   <= 1'b0;
            wait_cnt_reg  <= '0;
            bvalid_reg    <= 1'b0;
            rvalid_reg    <= 1'b0;
            rdata_reg     <= '0;
            bram_en_reg   <= 1'b0;
            bram_we_reg   <= '0;
            bram_addr_reg <= '0;
            bram_din_reg  <= '0;
        end else begin
            bram_en_reg <= 1'b0;
            bram_we_reg <= '0;
            case (state_reg)
                IDLE: begin
                    // On contention the side that did not win last time gets the port.
                    if (wr_req && (!rd_req || !last_wr_reg)) begin
                        state_reg     <= WR;
                        last_wr_reg   <= 1'b1;
                        bram_en_reg   <= 1'b1;
                        bram_we_reg   <= w_strb_reg;
                        bram_din_reg  <= w_data_reg;
                        bram_addr_reg <= aw_addr_reg;
                    end else if (rd_req) begin
                        state_reg     <= RD;
                        last_wr_reg   <= 1'b0;
                        bram_en_reg   <= 1'b1;
                        bram_addr_reg <= ar_addr_reg;
                    end
                end
                WR: begin
                    state_reg  <= WRESP;
                    bvalid_reg <= 1'b1;
                end
                WRESP: begin
                    if (s_axil_bready) begin
                        bvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                RD: begin
                    state_reg    <= RWAIT;
                    wait_cnt_reg <= 2'(RD_LATENCY - 1);
                end
                RWAIT: begin
                    if (wait_cnt_reg == 2'd0) begin
                        rdata_reg  <= bram_dout;
                        rvalid_reg <= 1'b1;
                        state_reg  <= RRESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 2'd1;
                    end
                end
                RRESP: begin
                    if (s_axil_rready) begin
                        rvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign s_axil_awready = awready_reg;
    assign s_axil_wready  = wready_reg;
    assign s_axil_arready = arready_reg;
    assign s_axil_bvalid  = bvalid_reg;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_rvalid  = rvalid_reg;
    assign s_axil_rresp   = 2'b00;
    assign s_axil_rdata   = rdata_reg;
    assign bram_en        = bram_en_reg;
    assign bram_we        = bram_we_reg;
    assign bram_addr      = bram_addr_reg;
    assign bram_din       = bram_din_reg;

    // Protection bits and byte offsets carry no meaning for a word-wide BRAM.
    assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                           s_axil_awaddr[BL-1:0], s_axil_araddr[BL-1:0]};

endmodule

// File: tb/tb_axil_bram_port_rr.sv
// Directed bench: a latency-1 instance does most of the work, a latency-2 instance
// shares the memory contents for the read-timing check.
module tb_axil_bram_port_rr;

    logic        axi_clock = 1'b0;
    logic        rst_n;
    logic [11:0] s_axil_awaddr, s_axil_araddr;
    logic [2:0]  s_axil_awprot, s_axil_arprot;
    logic        s_axil_awvalid, s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid, s_axil_wready;
    logic [1:0]  s_axil_bresp, s_axil_rresp;
    logic        s_axil_bvalid, s_axil_bready;
    logic        s_axil_arvalid, s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic        s_axil_rvalid, s_axil_rready;
    logic [9:0]  bram_addr;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_din, bram_dout;

    // latency-2 instance: read-only use
    logic [11:0] araddr2;
    logic        arvalid2, arready2, rvalid2, rready2, awready2, wready2, bvalid2;
    logic [31:0] rdata2, bram_din2, bram_dout2, pipe2;
    logic [1:0]  bresp2, rresp2;
    logic [9:0]  bram_addr2;
    logic        bram_en2;
    logic [3:0]  bram_we2;

    logic [31:0] mem [0:1023];
    bit          log_q[$];
    logic [3:0]  last_we;
    logic [9:0]  last_addr;
    int          en_count = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 axi_clock = ~axi_clock;

    axil_bram_port_rr #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RD_LATENCY(1)) dut (
        .axi_clock(axi_clock), .rst_n(rst_n),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    axil_bram_port_rr #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RD_LATENCY(2)) dut2 (
        .axi_clock(axi_clock), .rst_n(rst_n),
        .s_axil_awaddr(12'h0), .s_axil_awprot(3'b000),
        .s_axil_awvalid(1'b0), .s_axil_awready(awready2),
        .s_axil_wdata(32'h0), .s_axil_wstrb(4'h0),
        .s_axil_wvalid(1'b0), .s_axil_wready(wready2),
        .s_axil_bresp(bresp2), .s_axil_bvalid(bvalid2), .s_axil_bready(1'b1),
        .s_axil_araddr(araddr2), .s_axil_arprot(3'b000),
        .s_axil_arvalid(arvalid2), .s_axil_arready(arready2),
        .s_axil_rdata(rdata2), .s_axil_rresp(rresp2),
        .s_axil_rvalid(rvalid2), .s_axil_rready(rready2),
        .bram_addr(bram_addr2), .bram_en(bram_en2), .bram_we(bram_we2),
        .bram_din(bram_din2), .bram_dout(bram_dout2)
    );

    // BRAM model for the latency-1 port, plus an access log
    always @(posedge axi_clock) begin
        if (bram_en) begin
            for (int i = 0; i < 4; i++)
                if (bram_we[i]) mem[bram_addr][8*i +: 8] <= bram_din[8*i +: 8];
            bram_dout <= mem[bram_addr];
            log_q.push_back(bram_we != 4'h0);
            last_we   <= bram_we;
            last_addr <= bram_addr;
            en_count  <= en_count + 1;
        end
    end

    // two-stage read pipe for the latency-2 port
    always @(posedge axi_clock) begin
        if (bram_en2) pipe2 <= mem[bram_addr2];
        bram_dout2 <= pipe2;
    end

    task automatic tick;
        @(posedge axi_clock);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done = 0;
        int n = 0;
        s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = strb;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            if (s_axil_awvalid && s_axil_awready) aw_done = 1;
            if (s_axil_wvalid && s_axil_wready) w_done = 1;
            tick;
            if (aw_done) s_axil_awvalid = 1'b0;
            if (w_done) s_axil_wvalid = 1'b0;
            n++;
        end
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        n = 0;
        while (!s_axil_bvalid && n < 50) begin
            tick;
            n++;
        end
        vectors++;
        if (!s_axil_bvalid) begin
            miscompares++;
            $display("FAIL write_bvalid_timeout addr=%h actual=0 required=1", addr);
        end
        resp = s_axil_bresp;
        tick;
    endtask

    task automatic axi_read(input logic [11:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n = 0;
        bit ar_done = 0;
        s_axil_araddr = addr;
        s_axil_arvalid = 1'b1;
        while (!ar_done && n < 50) begin
            if (s_axil_arready) ar_done = 1;
            tick;
            n++;
        end
        s_axil_arvalid = 1'b0;
        n = 0;
        while (!s_axil_rvalid && n < 50) begin
            tick;
            n++;
        end
        vectors++;
        if (!s_axil_rvalid) begin
            miscompares++;
            $display("FAIL read_rvalid_timeout addr=%h actual=0 required=1", addr);
        end
        data = s_axil_rdata;
        resp = s_axil_rresp;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick;
        vectors++;
        if ({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid, bram_en, bram_we} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_outputs actual=%b required=0", {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid, bram_en, bram_we});
        end
        rst_n = 1'b1;
        vectors++;
        if (s_axil_awready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_before_edge actual=%b required=0", s_axil_awready);
        end
        tick;
        vectors++;
        if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b111) begin
            miscompares++;
            $display("FAIL ready_after_edge actual=%b required=111", {s_axil_awready, s_axil_wready, s_axil_arready});
        end
        $display("reset: readys=%b", {s_axil_awready, s_axil_wready, s_axil_arready});
    endtask

    task automatic test_write_read;
        s_axil_awaddr = 12'h010; s_axil_wdata = 32'hDEADBEEF; s_axil_wstrb = 4'hF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        tick;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        vectors++;
        if ({bram_en, s_axil_awready, s_axil_wready} !== 3'b000) begin
            miscompares++;
            $display("FAIL wr_capture_cycle actual=%b required=000", {bram_en, s_axil_awready, s_axil_wready});
        end
        tick;
        vectors++;
        if ({bram_en, bram_we, bram_addr, bram_din} !== {1'b1, 4'hF, 10'd4, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL wr_bram_access actual=%b/%h/%0d/%h required=1/f/4/deadbeef", bram_en, bram_we, bram_addr, bram_din);
        end
        tick;
        vectors++;
        if ({s_axil_bvalid, s_axil_bresp, bram_en} !== 4'b1000) begin
            miscompares++;
            $display("FAIL wr_bvalid actual=%b required=1000", {s_axil_bvalid, s_axil_bresp, bram_en});
        end
        tick;
        vectors++;
        if (s_axil_bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_bvalid_drop actual=%b required=0", s_axil_bvalid);
        end
        s_axil_araddr = 12'h010; s_axil_arvalid = 1'b1;
        tick;
        s_axil_arvalid = 1'b0;
        tick;
        vectors++;
        if ({bram_en, bram_we, bram_addr} !== {1'b1, 4'h0, 10'd4}) begin
            miscompares++;
            $display("FAIL rd_bram_access actual=%b/%h/%0d required=1/0/4", bram_en, bram_we, bram_addr);
        end
        tick;
        vectors++;
        if (s_axil_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_early_rvalid actual=%b required=0", s_axil_rvalid);
        end
        tick;
        vectors++;
        if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL rd_data actual=%b/%b/%h required=1/00/deadbeef", s_axil_rvalid, s_axil_rresp, s_axil_rdata);
        end
        $display("write_read: rdata=%h", s_axil_rdata);
        tick;
    endtask

    task automatic test_strobe;
        logic [1:0]  resp;
        logic [31:0] data;
        int base;
        axi_write(12'h020, 32'h11223344, 4'hF, resp);
        axi_write(12'h020, 32'hAABBCCDD, 4'b0010, resp);
        axi_read(12'h020, data, resp);
        vectors++;
        if (data !== 32'h1122CC44) begin
            miscompares++;
            $display("FAIL strobe_merge actual=%h required=1122cc44", data);
        end
        base = en_count;
        axi_write(12'h020, 32'hFFFFFFFF, 4'h0, resp);
        vectors++;
        if ({resp, last_we} !== 6'b0 || en_count !== base + 1) begin
            miscompares++;
            $display("FAIL zero_strobe actual=resp %b we %h en %0d required=00/0/%0d", resp, last_we, en_count, base + 1);
        end
        axi_read(12'h023, data, resp);
        vectors++;
        if ({data, resp} !== {32'h1122CC44, 2'b00}) begin
            miscompares++;
            $display("FAIL low_bits_ignored actual=%h/%b required=1122cc44/00", data, resp);
        end
        $display("strobe: merged=%h", data);
    endtask

    task automatic test_arbitration;
        int n = 0;
        do_reset;
        log_q.delete();
        s_axil_awaddr = 12'h040; s_axil_wdata = 32'hA5A50000; s_axil_wstrb = 4'hF;
        s_axil_araddr = 12'h044;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
        while (log_q.size() < 16 && n < 400) begin
            tick;
            n++;
        end
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        repeat (40) tick;
        vectors++;
        if (log_q.size() < 16) begin
            miscompares++;
            $display("FAIL arb_access_count actual=%0d required=16", log_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                vectors++;
                if (log_q[i] !== ((i % 2) == 0)) begin
                    miscompares++;
                    $display("FAIL arb_order idx=%0d actual_write=%b required_write=%b", i, log_q[i], (i % 2) == 0);
                end
            end
        end
        $display("arbitration: %0d accesses logged", log_q.size());
    endtask

    task automatic test_w_before_aw;
        int base;
        int bcount = 0;
        s_axil_wdata = 32'h12345678; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        tick;
        s_axil_wvalid = 1'b0;
        base = en_count;
        vectors++;
        if (s_axil_wready !== 1'b0) begin
            miscompares++;
            $display("FAIL w_first_wready actual=%b required=0", s_axil_wready);
        end
        repeat (4) tick;
        vectors++;
        if (en_count !== base) begin
            miscompares++;
            $display("FAIL w_first_no_access actual=%0d required=%0d", en_count, base);
        end
        s_axil_awaddr = 12'h030; s_axil_awvalid = 1'b1;
        tick;
        s_axil_awvalid = 1'b0;
        repeat (10) begin
            if (s_axil_bvalid) bcount++;
            tick;
        end
        vectors++;
        if (bcount !== 1) begin
            miscompares++;
            $display("FAIL w_first_bvalid_count actual=%0d required=1", bcount);
        end
        vectors++;
        if ({en_count == base + 1, last_addr, last_we, s_axil_wready} !== {1'b1, 10'd12, 4'hF, 1'b1}) begin
            miscompares++;
            $display("FAIL w_first_access actual=en %0d addr %0d we %h wready %b required=%0d/12/f/1", en_count, last_addr, last_we, s_axil_wready, base + 1);
        end
        $display("w_before_aw: bvalid cycles=%0d", bcount);
    endtask

    task automatic test_backpressure;
        int n = 0;
        int base;
        bit aw_done = 0;
        bit w_done = 0;
        logic [31:0] data;
        logic [1:0]  resp;
        s_axil_rready = 1'b0;
        s_axil_araddr = 12'h010; s_axil_arvalid = 1'b1;
        tick;
        s_axil_arvalid = 1'b0;
        while (!s_axil_rvalid && n < 20) begin
            tick;
            n++;
        end
        base = en_count;
        s_axil_awaddr = 12'h050; s_axil_wdata = 32'h0BADF00D; s_axil_wstrb = 4'hF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if ({s_axil_rvalid, s_axil_rdata} !== {1'b1, 32'hDEADBEEF}) begin
                miscompares++;
                $display("FAIL stall_rdata cycle=%0d actual=%b/%h required=1/deadbeef", c, s_axil_rvalid, s_axil_rdata);
            end
            if (s_axil_awvalid && s_axil_awready) aw_done = 1;
            if (s_axil_wvalid && s_axil_wready) w_done = 1;
            tick;
            if (aw_done) s_axil_awvalid = 1'b0;
            if (w_done) s_axil_wvalid = 1'b0;
        end
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        vectors++;
        if ({en_count == base, s_axil_awready, s_axil_wready} !== 3'b100) begin
            miscompares++;
            $display("FAIL stall_write_waits actual=en %0d readys %b required=%0d/00", en_count, {s_axil_awready, s_axil_wready}, base);
        end
        s_axil_rready = 1'b1;
        tick;
        vectors++;
        if (s_axil_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release actual=%b required=0", s_axil_rvalid);
        end
        n = 0;
        while (!s_axil_bvalid && n < 20) begin
            tick;
            n++;
        end
        vectors++;
        if ({s_axil_bvalid, last_addr, en_count == base + 1} !== {1'b1, 10'd20, 1'b1}) begin
            miscompares++;
            $display("FAIL queued_write actual=bvalid %b addr %0d en %0d required=1/20/%0d", s_axil_bvalid, last_addr, en_count, base + 1);
        end
        tick;
        axi_read(12'h050, data, resp);
        vectors++;
        if (data !== 32'h0BADF00D) begin
            miscompares++;
            $display("FAIL queued_write_data actual=%h required=0badf00d", data);
        end
        // latency-2 instance: AR at edge E -> rvalid in cycle E+4
        araddr2 = 12'h010; arvalid2 = 1'b1;
        tick;
        arvalid2 = 1'b0;
        repeat (3) tick;
        vectors++;
        if (rvalid2 !== 1'b0) begin
            miscompares++;
            $display("FAIL lat2_early actual=%b required=0", rvalid2);
        end
        tick;
        vectors++;
        if ({rvalid2, rdata2} !== {1'b1, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL lat2_data actual=%b/%h required=1/deadbeef", rvalid2, rdata2);
        end
        tick;
        $display("backpressure: queued write=%h lat2 rdata=%h", data, rdata2);
    endtask

    task automatic test_reset_midread;
        int stale = 0;
        logic [31:0] data;
        logic [1:0]  resp;
        s_axil_araddr = 12'h010; s_axil_arvalid = 1'b1;
        tick;
        s_axil_arvalid = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({s_axil_rvalid, s_axil_bvalid, s_axil_arready, s_axil_awready, s_axil_wready, bram_en} !== 6'b0) begin
            miscompares++;
            $display("FAIL midread_reset actual=%b required=000000", {s_axil_rvalid, s_axil_bvalid, s_axil_arready, s_axil_awready, s_axil_wready, bram_en});
        end
        tick;
        tick;
        rst_n = 1'b1;
        repeat (8) begin
            tick;
            if (s_axil_rvalid) stale++;
        end
        vectors++;
        if (stale !== 0) begin
            miscompares++;
            $display("FAIL stale_response actual=%0d required=0", stale);
        end
        axi_read(12'h050, data, resp);
        vectors++;
        if ({data, resp} !== {32'h0BADF00D, 2'b00}) begin
            miscompares++;
            $display("FAIL read_after_reset actual=%h/%b required=0badf00d/00", data, resp);
        end
        $display("reset_midread: stale=%0d rdata=%h", stale, data);
    endtask

    initial begin
        rst_n = 1'b0;
        s_axil_awaddr = '0; s_axil_awprot = 3'b000; s_axil_awvalid = 1'b0;
        s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
        s_axil_bready = 1'b1;
        s_axil_araddr = '0; s_axil_arprot = 3'b000; s_axil_arvalid = 1'b0;
        s_axil_rready = 1'b1;
        araddr2 = '0; arvalid2 = 1'b0; rready2 = 1'b1;
        test_reset;
        test_write_read;
        test_strobe;
        test_arbitration;
        test_w_before_aw;
        test_backpressure;
        test_reset_midread;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
